// File: rtl/riscv_alu_pkg.sv
// Shared definitions for the execute-stage ALU with RV32M multiply/divide:
// op codes, FSM state encoding and small op classification helpers.
package riscv_alu_pkg;

    // Legacy single-cycle codes
    localparam int unsigned ALU_AND    = 0;
    localparam int unsigned ALU_OR     = 1;
    localparam int unsigned ALU_ADD    = 2;
    localparam int unsigned ALU_SUB    = 6;
    localparam int unsigned ALU_SLTU   = 7;
    localparam int unsigned ALU_NOR    = 12;
    // Added single-cycle codes
    localparam int unsigned ALU_XOR    = 3;
    localparam int unsigned ALU_SLL    = 4;
    localparam int unsigned ALU_SRL    = 5;
    localparam int unsigned ALU_SLT    = 8;
    localparam int unsigned ALU_SRA    = 9;
    // Iterative codes (low three bits select the mul/div variant)
    localparam int unsigned ALU_MUL    = 16;
    localparam int unsigned ALU_MULH   = 17;
    localparam int unsigned ALU_MULHSU = 18;
    localparam int unsigned ALU_MULHU  = 19;
    localparam int unsigned ALU_DIV    = 20;
    localparam int unsigned ALU_DIVU   = 21;
    localparam int unsigned ALU_REM    = 22;
    localparam int unsigned ALU_REMU   = 23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ONE  = 2'd1,
        ST_ITER = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    // Mul/div variant, equal to the low three bits of the iterative op code
    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_t;

    function automatic logic is_iterative(input logic [31:0] ctl);
        return (ctl >= ALU_MUL) && (ctl <= ALU_REMU);
    endfunction

    // MUL low half is sign-agnostic, so it is run unsigned
    function automatic logic op_signed_a(input md_op_t op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic op_signed_b(input md_op_t op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/riscv_iter_muldiv.sv
// Iterative engine: shift-add multiplier / restoring divider on operand
// magnitudes, one bit per cycle for XLEN cycles, plus the final sign and
// corner-case correction applied combinationally on the settled accumulator.
module riscv_iter_muldiv
    import riscv_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  md_op_t          op_i,
    input  logic [XLEN-1:0] a_mag_i,
    input  logic [XLEN-1:0] b_mag_i,
    input  logic            a_neg_i,
    input  logic            b_neg_i,
    output logic            fin_o,
    output logic [XLEN-1:0] value_o
);

    localparam int CNT_W = $clog2(XLEN);

    logic [2*XLEN-1:0] acc_q, acc_d, acc_step;
    logic [XLEN-1:0]   b_q;
    md_op_t            op_q;
    logic              a_neg_q, b_neg_q, b_zero_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_q, run_d;
    logic              last_step;

    logic [XLEN:0]     mul_sum, div_rem_sh, div_trial;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo, rem, quo_s, rem_s;

    assign last_step = run_q && (cnt_q == CNT_W'(XLEN - 1));
    assign fin_o     = last_step;

    // One iteration step: multiplier adds b on the LSB and shifts right;
    // divider shifts in the next dividend bit and subtracts b if it fits
    always_comb begin
        mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        div_rem_sh = acc_q[2*XLEN-1:XLEN-1];
        div_trial  = div_rem_sh - {1'b0, b_q};
        acc_step   = {mul_sum, acc_q[XLEN-1:1]};
        if (op_q[2]) begin
            if (div_trial[XLEN]) begin
                acc_step = {div_rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end else begin
                acc_step = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end
        end
    end

    // Next-state for accumulator, counter and run flag; load has priority
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (load_i) begin
            acc_d = {{XLEN{1'b0}}, a_mag_i};
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            acc_d = acc_step;
            cnt_d = cnt_q + 1'b1;
            if (last_step) begin
                run_d = 1'b0;
            end
        end
    end

    // Engine state registers; operand attributes captured on load only
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            b_q      <= '0;
            op_q     <= MD_MUL;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
            if (load_i) begin
                b_q      <= b_mag_i;
                op_q     <= op_i;
                a_neg_q  <= a_neg_i;
                b_neg_q  <= b_neg_i;
                b_zero_q <= (b_mag_i == '0);
            end
        end
    end

    // Sign correction and RISC-V division corners. Overflow (most-negative
    // by -1) falls out naturally: magnitude quotient 2^(XLEN-1), sign positive.
    always_comb begin
        prod_s  = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
        quo     = acc_q[XLEN-1:0];
        rem     = acc_q[2*XLEN-1:XLEN];
        quo_s   = b_zero_q ? {XLEN{1'b1}} : ((a_neg_q ^ b_neg_q) ? -quo : quo);
        rem_s   = a_neg_q ? -rem : rem;
        value_o = rem_s;
        case (op_q)
            MD_MUL:                        value_o = prod_s[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  value_o = prod_s[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               value_o = quo_s;
            default:                       value_o = rem_s;
        endcase
    end

endmodule

// File: rtl/riscv_alu_mdu.sv
// Execute-stage ALU: single-cycle logic/arith/shift/compare ops plus the
// RV32M set on an iterative engine, behind a start/done handshake.
//
// Handshake: start is accepted on a rising edge when the FSM is IDLE or ONE
// (never while busy); operands are sampled only on that edge. done pulses for
// exactly one cycle and result/zero stay valid and held until the next done.
// A start presented during the done cycle is accepted.
module riscv_alu_mdu
    import riscv_alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CTL_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CTL_W-1:0] alu_ctl,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic             zero,
    output state_t           state_dbg
);

    localparam int SH_W = $clog2(XLEN);

    state_t          state_q, state_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;

    logic [31:0]     ctl32;
    logic            op_iter;
    logic            accept;
    logic [SH_W-1:0] shamt;
    logic [XLEN-1:0] alu_y;

    md_op_t          md_op;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            md_load;
    logic            md_fin;
    logic [XLEN-1:0] md_value;

    assign ctl32   = 32'(alu_ctl);
    assign op_iter = is_iterative(ctl32);
    assign accept  = start && ((state_q == ST_IDLE) || (state_q == ST_ONE));
    assign shamt   = b[SH_W-1:0];

    // Single-cycle datapath on the live operands
    always_comb begin
        alu_y = '0;
        case (ctl32)
            ALU_AND:  alu_y = a & b;
            ALU_OR:   alu_y = a | b;
            ALU_ADD:  alu_y = a + b;
            ALU_XOR:  alu_y = a ^ b;
            ALU_SLL:  alu_y = a << shamt;
            ALU_SRL:  alu_y = a >> shamt;
            ALU_SUB:  alu_y = a - b;
            ALU_SLTU: alu_y = XLEN'(a < b);
            ALU_SLT:  alu_y = XLEN'($signed(a) < $signed(b));
            ALU_SRA:  alu_y = XLEN'($signed(a) >>> shamt);
            ALU_NOR:  alu_y = ~(a | b);
            default:  alu_y = '0;
        endcase
    end

    // Operand conditioning for the engine: magnitude plus recorded sign
    always_comb begin
        md_op = md_op_t'(ctl32[2:0]);
        a_neg = op_signed_a(md_op) && a[XLEN-1];
        b_neg = op_signed_b(md_op) && b[XLEN-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    riscv_iter_muldiv #(
        .XLEN(XLEN)
    ) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (md_load),
        .op_i    (md_op),
        .a_mag_i (a_mag),
        .b_mag_i (b_mag),
        .a_neg_i (a_neg),
        .b_neg_i (b_neg),
        .fin_o   (md_fin),
        .value_o (md_value)
    );

    // FSM next state; ONE marks the done cycle of a single-cycle op and
    // accepts a new start just like IDLE
    always_comb begin
        state_d = state_q;
        md_load = 1'b0;
        case (state_q)
            ST_IDLE, ST_ONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    if (op_iter) begin
                        state_d = ST_ITER;
                        md_load = 1'b1;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
            end
            ST_ITER: begin
                if (md_fin) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output register next values: single-cycle result lands on the accept
    // edge, iterative result on the edge leaving FIX
    always_comb begin
        result_d = result_q;
        done_d   = 1'b0;
        if (accept && !op_iter) begin
            result_d = alu_y;
            done_d   = 1'b1;
        end else if (state_q == ST_FIX) begin
            result_d = md_value;
            done_d   = 1'b1;
        end
        zero_d = (result_d == '0);
        busy_d = (state_d == ST_ITER) || (state_d == ST_FIX);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_riscv_alu_mdu.sv
// Directed plus small randomized bench for riscv_alu_mdu (XLEN=32).
module tb_riscv_alu_mdu;

    localparam int W       = 32;
    localparam int LAT_ONE = 1;
    localparam int LAT_IT  = W + 2;
    localparam int BUSY_IT = W + 1;

    localparam logic [4:0] C_AND = 5'd0,  C_OR = 5'd1,  C_ADD = 5'd2,  C_XOR = 5'd3;
    localparam logic [4:0] C_SLL = 5'd4,  C_SRL = 5'd5, C_SUB = 5'd6,  C_SLTU = 5'd7;
    localparam logic [4:0] C_SLT = 5'd8,  C_SRA = 5'd9, C_NOR = 5'd12, C_BAD = 5'd10;
    localparam logic [4:0] C_MUL = 5'd16, C_MULH = 5'd17, C_MULHSU = 5'd18, C_MULHU = 5'd19;
    localparam logic [4:0] C_DIV = 5'd20, C_DIVU = 5'd21, C_REM = 5'd22,   C_REMU = 5'd23;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [4:0]   alu_ctl;
    logic [W-1:0] a, b;
    logic         busy, done, zero;
    logic [W-1:0] result;
    logic [1:0]   state_dbg;

    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    riscv_alu_mdu #(.XLEN(W), .CTL_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .alu_ctl   (alu_ctl),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .zero      (zero),
        .state_dbg (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog timeout n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference results computed with wide arithmetic
    function automatic logic [W-1:0] ref_model(input logic [4:0] ctl, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0]        pu;
        logic signed [2*W-1:0] ps;
        logic [4:0]            sh;
        pu = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        ps = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
        sh = y[4:0];
        case (ctl)
            C_AND:   return x & y;
            C_OR:    return x | y;
            C_ADD:   return x + y;
            C_XOR:   return x ^ y;
            C_SLL:   return x << sh;
            C_SRL:   return x >> sh;
            C_SUB:   return x - y;
            C_MUL:   return pu[W-1:0];
            C_MULH:  return ps[2*W-1:W];
            C_MULHU: return pu[2*W-1:W];
            C_DIV:   return $signed(x) / $signed(y);
            C_DIVU:  return x / y;
            C_REM:   return $signed(x) % $signed(y);
            C_REMU:  return x % y;
            default: return '0;
        endcase
    endfunction

    // Present an op at the current time and push its expected result
    task automatic drive(input logic [4:0] ctl, input logic [W-1:0] av, input logic [W-1:0] bv, input logic [W-1:0] ev);
        alu_ctl = ctl;
        a       = av;
        b       = bv;
        start   = 1'b1;
        exp_q.push_back(ev);
    endtask

    // Wait (bounded) for done, then pop the scoreboard and compare
    task automatic wait_done(input string tag, input int exp_lat, input int exp_busy, input bit drop_on_done);
        int           cyc;
        int           busy_cnt;
        logic         got;
        logic [W-1:0] ev;
        cyc = 0;
        busy_cnt = 0;
        got = 1'b0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) got = 1'b1;
        end
        if (drop_on_done) start = 1'b0;
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        if (exp_q.size() > 0) begin
            ev = exp_q.pop_front();
        end else begin
            ev = 'x;
        end
        check({tag, "_result"}, 64'(result), 64'(ev));
        check({tag, "_zero"}, 64'(zero), 64'(ev == '0));
    endtask

    task automatic run(input string tag, input logic [4:0] ctl, input logic [W-1:0] av, input logic [W-1:0] bv, input logic [W-1:0] ev);
        bit iter;
        iter = (ctl >= C_MUL) && (ctl <= C_REMU);
        @(negedge clk);
        drive(ctl, av, bv, ev);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(tag, iter ? LAT_IT : LAT_ONE, iter ? BUSY_IT : 0, 1'b0);
    endtask

    // One cycle after done: pulse gone, result held
    task automatic check_hold(input string tag, input logic [W-1:0] ev);
        @(negedge clk);
        check({tag, "_done_low"}, 64'(done), 64'd0);
        check({tag, "_busy_low"}, 64'(busy), 64'd0);
        check({tag, "_held"}, 64'(result), 64'(ev));
    endtask

    logic [4:0] rnd_ops[11] = '{C_AND, C_OR, C_ADD, C_XOR, C_SLL, C_SRL, C_SUB, C_MUL, C_MULH, C_DIVU, C_REM};

    initial begin
        int           pulses;
        logic [4:0]   op;
        logic [W-1:0] ra, rb;

        rst_n   = 1'b0;
        start   = 1'b0;
        alu_ctl = '0;
        a       = '0;
        b       = '0;

        // Reset held three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_zero", 64'(zero), 64'd1);
        check("rst_state", 64'(state_dbg), 64'd0);
        rst_n = 1'b1;

        // Single-cycle ops
        run("add", C_ADD, 32'd7, 32'd5, 32'd12);
        check_hold("add", 32'd12);
        run("sub_zero", C_SUB, 32'd5, 32'd5, 32'd0);
        check_hold("sub_zero", 32'd0);
        run("sltu", C_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
        run("slt", C_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
        run("nor", C_NOR, 32'd0, 32'd0, 32'hFFFF_FFFF);
        run("xor", C_XOR, 32'hA5A5_0F0F, 32'hFFFF_0000, 32'h5A5A_0F0F);
        run("sll_upper_b", C_SLL, 32'd1, 32'h0000_0123, 32'd8);
        run("srl_upper_b", C_SRL, 32'h8000_0000, 32'hFFFF_FFE1, 32'h4000_0000);
        run("bad_op", C_BAD, 32'h1234_5678, 32'h1, 32'd0);

        // Multiply
        run("mulh", C_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run("mulhsu", C_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run("mul_low", C_MUL, 32'h8000_0000, 32'h8000_0000, 32'd0);
        run("mulhu", C_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        check_hold("mulhu", 32'hFFFF_FFFE);

        // Division corners
        run("div_by0", C_DIV, 32'd7, 32'd0, 32'hFFFF_FFFF);
        run("remu_by0", C_REMU, 32'd7, 32'd0, 32'd7);
        run("div_ovf", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run("rem_ovf", C_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run("div_neg", C_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run("rem_neg", C_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);

        // start held high through a DIV: only the first is accepted
        @(negedge clk);
        drive(C_DIV, 32'd100, 32'd7, 32'd14);
        @(posedge clk);
        #1;
        alu_ctl = C_ADD;
        a       = 32'd1;
        b       = 32'd1;
        wait_done("div_held_start", LAT_IT, BUSY_IT, 1'b1);
        check_hold("div_held_start", 32'd14);

        // start in the done cycle of a DIVU is accepted
        run("divu_b2b", C_DIVU, 32'd100, 32'd7, 32'd14);
        drive(C_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("sra_in_done", LAT_ONE, 0, 1'b0);

        // Randomized ops against the wide-arithmetic model
        for (int i = 0; i < 10; i++) begin
            op = rnd_ops[$urandom_range(0, 10)];
            ra = $urandom();
            rb = $urandom();
            if (rb == '0) rb = 32'd3;
            if (rb == 32'hFFFF_FFFF) rb = 32'd5;
            run($sformatf("rnd%0d_op%0d", i, op), op, ra, rb, ref_model(op, ra, rb));
        end

        // Reset in the middle of a MUL
        @(negedge clk);
        drive(C_MUL, 32'd3, 32'd5, 32'd15);
        @(posedge clk);
        #1 start = 1'b0;
        void'(exp_q.pop_back());
        repeat (9) @(negedge clk);
        check("midrst_busy_before", 64'(busy), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        check("midrst_zero", 64'(zero), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("midrst_no_done", 64'(pulses), 64'd0);
        check("midrst_idle", 64'(state_dbg), 64'd0);
        run("add_after_rst", C_ADD, 32'd2, 32'd3, 32'd5);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_alu_mdu.md
# riscv_alu_mdu

Parametrised successor to the multicycle datapath ALU. It adds XOR, shifts, signed compare and the full RV32M multiply/divide set behind a start/done handshake. Single-cycle ops complete in one clock. MUL/DIV ops run on an iterative shift-add / restoring-divide engine with fixed latency. Sits in the execute stage of the multicycle CPU; the control FSM holds in EX until `done`.

## Interface
- `XLEN`, default 32: operand/result width; legal values 8..64, even.
- `CTL_W`, default 5: width of the op select.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: accept `alu_ctl`/`a`/`b` this cycle; ignored while `busy`.
- `alu_ctl` in CTL_W: op select (encoding below).
- `a`, `b` in XLEN: operands; sampled only on accepted `start`.
- `busy` out 1: iterative op in progress.
- `done` out 1: one-cycle pulse; `result` valid from this cycle.
- `result` out XLEN: registered result; held until the next `done`.
- `zero` out 1: registered `result == 0`, updated with `result`.

## Operation
- Op codes. Legacy codes are unchanged:
  - 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLTU (unsigned a<b → 1 else 0), 12 NOR.
  - New single-cycle: 3 XOR, 4 SLL, 5 SRL, 9 SRA, 8 SLT (signed). Shift amount is `b[$clog2(XLEN)-1:0]`; upper bits of `b` are ignored.
  - Iterative: 16 MUL (low half), 17 MULH (s×s), 18 MULHSU (signed a × unsigned b), 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - Any other code: single-cycle, result 0.
- Arithmetic wraps modulo 2^XLEN. No flags other than `zero`.
- FSM states:
  - IDLE → ONE on start with a single-cycle op.
  - IDLE → ITER on start with an iterative op.
  - ONE → IDLE, writing `result` and pulsing `done`.
  - ITER runs exactly XLEN cycles, one bit per cycle, then → FIX.
  - FIX applies sign correction, writes `result`, pulses `done`, → IDLE.
- Operand conditioning on entry to ITER:
  - Signed operands are converted to magnitude with a recorded sign.
  - The multiplier keeps the full 2·XLEN product; MUL returns the low half, MULH* the high half.
- Division corner cases (RISC-V semantics, decided in FIX, constant latency):
  - b=0: DIV/DIVU → all-ones; REM/REMU → a.
  - DIV/REM with a = most-negative and b = −1: quotient = a, remainder = 0.
- `start` while `busy`: ignored; operands are not sampled.
- `start` in the same cycle as `done`: accepted, since the FSM is in IDLE that cycle.

## Timing
- Start accepted at edge T.
- Single-cycle ops: `done`=1 and `result` valid in cycle T+1; `busy` stays 0.
- Iterative ops:
  - `busy`=1 in cycles T+1 .. T+XLEN+1.
  - `done`=1 and `result` valid in cycle T+XLEN+2 (34 for XLEN=32); `busy`=0 in that cycle.
- `done` is exactly one cycle wide; `result`/`zero` hold afterwards.
- Reset values: `busy`=0, `done`=0, `result`=0, `zero`=1, FSM=IDLE.
- Reset mid-operation:
  - Abort at the next edge with `rst_n`=0; all outputs go to reset values.
  - No `done` for the aborted op.
  - The first start after reset release behaves normally.

## Structure
- Package `riscv_alu_pkg` holds:
  - op-code localparams (`ALU_AND` … `ALU_REMU`);
  - FSM state encoding (IDLE, ONE, ITER, FIX);
  - helper function `is_iterative(ctl)`.
- Sub-module `riscv_iter_muldiv`:
  - contains the iteration counter, the 2·XLEN accumulator/remainder register and the FIX correction;
  - interface `load`, op, magnitudes, signs → `fin`, value.
- The top level contains the single-cycle datapath, the FSM and the output registers.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles → `busy`=0, `done`=0, `result`=0, `zero`=1.
- Legacy ops: ADD a=7, b=5 → `done` at T+1 with result 12. SUB 5−5 → 0 with `zero`=1. SLTU 0xFFFFFFFF<1 → 0. SLT 0xFFFFFFFF<1 → 1. NOR 0,0 → 0xFFFFFFFF.
- Multiply: MULH a=0x80000000, b=0x80000000 → 0x40000000 at exactly T+34, `busy` high for 33 cycles. MULHSU a=−1, b=0xFFFFFFFF → 0xFFFFFFFF. MUL → 0.
- Division corners: DIV 7/0 → 0xFFFFFFFF. REMU 7/0 → 7. DIV 0x80000000/−1 → 0x80000000 with REM 0. DIV −7/2 → −3 with REM −1. All complete at T+34.
- Handshake: assert `start` every cycle during a DIV → only the first is accepted. `start` with SRA 0x80000000>>4 in the `done` cycle → result 0xF8000000 at the following cycle.
- Reset mid-op: deassert `rst_n` at T+10 of a MUL → no `done` ever for it, outputs reset. A fresh ADD after release completes at T+1.
